// File: rtl/memory_pkg.sv
// Shared types for memory_bank: sequencer states and the R_W encodings.
package memory_pkg;

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_e;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/memory_array.sv
// Single-port storage for memory_bank: synchronous write, registered read.
// The array keeps the name Memory so bench dumps resolve as ram.u_array.Memory.
module memory_array #(
   parameter int W      = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [W-1:0]      wdata,
   output logic [W-1:0]      rdata
);

   logic [W-1:0] Memory [0:DEPTH-1];
   logic [W-1:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (we) begin
         Memory[addr] <= wdata;
      end
   end

   // Read register only loads on a read, so the last read word is held
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_reg <= '0;
      end else if (re) begin
         rdata_reg <= Memory[addr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/memory_bank.sv
// Parametrised data memory with request/ready handshake, range check and a
// zero-fill sequencer. Define MEM_PARITY_EN to store and check an even-parity bit.
module memory_bank
   import memory_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              R_W,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] D_In,
   input  logic              clear,
   output logic              ready,
   output logic [DATA_W-1:0] D_Out,
   output logic              valid,
   output logic              error,
   output logic              perr
);

`ifdef MEM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int WORD_W = DATA_W + PAR_W;
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e              state_reg, state_next;
   logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;
   logic                valid_reg, valid_next;
   logic                error_reg, error_next;
   logic                accept;
   logic                in_range;
   logic                mem_we, mem_re;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WORD_W-1:0]   mem_wdata, mem_rdata, write_word;

   assign ready    = (state_reg == ST_IDLE) && !clear;
   assign accept   = enable && ready;
   assign in_range = {1'b0, Address} < DEPTH_L;

`ifdef MEM_PARITY_EN
   assign write_word = {^D_In, D_In};
`else
   assign write_word = D_In;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_CLEAR;
         clr_addr_reg <= '0;
         valid_reg    <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         clr_addr_reg <= clr_addr_next;
         valid_reg    <= valid_next;
         error_reg    <= error_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      clr_addr_next = clr_addr_reg;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
      mem_addr      = Address;
      mem_wdata     = write_word;
      valid_next    = 1'b0;
      error_next    = 1'b0;
      case (state_reg)
         ST_CLEAR: begin
            // clear requests are not looked at here, so a sweep never restarts
            mem_we    = 1'b1;
            mem_addr  = clr_addr_reg;
            mem_wdata = '0;
            if (clr_addr_reg == LAST_ADDR) begin
               state_next = ST_IDLE;
            end else begin
               clr_addr_next = clr_addr_reg + 1'b1;
            end
         end
         ST_IDLE: begin
            if (clear) begin
               state_next    = ST_CLEAR;
               clr_addr_next = '0;
            end else if (accept) begin
               if (!in_range) begin
                  error_next = 1'b1;
               end else if (R_W == RW_READ) begin
                  mem_re     = 1'b1;
                  valid_next = 1'b1;
               end else begin
                  mem_we = 1'b1;
               end
            end
         end
         default: state_next = ST_CLEAR;
      endcase
   end

   memory_array #(
      .W      (WORD_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign D_Out = mem_rdata[DATA_W-1:0];
   assign valid = valid_reg;
   assign error = error_reg;

`ifdef MEM_PARITY_EN
   // stored word includes its parity bit, so a clean word reduces to 0
   assign perr = valid_reg && (^mem_rdata);
`else
   assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank (DEPTH=6) with a read-data scoreboard.
module tb_memory_bank;
   import memory_pkg::*;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 6;

   logic              clk;
   logic              reset;
   logic              enable;
   logic              R_W;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] D_In;
   logic              clear;
   logic              ready;
   logic [DATA_W-1:0] D_Out;
   logic              valid;
   logic              error;
   logic              perr;

   int          checks;
   int          failures;
   logic [15:0] model [DEPTH];
   logic [15:0] sb_q [$];
   logic [15:0] last_dout;
   logic        perr_exp;

   memory_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .R_W     (R_W),
      .Address (Address),
      .D_In    (D_In),
      .clear   (clear),
      .ready   (ready),
      .D_Out   (D_Out),
      .valid   (valid),
      .error   (error),
      .perr    (perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one request at posedge+1, checks ready, then checks the result after the edge.
   task automatic cycle(input logic en, input logic rw, input logic [2:0] addr,
                        input logic [15:0] din, input logic clr, input logic exp_rdy);
      logic        acc, inr, exp_v, exp_e;
      logic [15:0] got;
      enable  = en;
      R_W     = rw;
      Address = addr;
      D_In    = din;
      clear   = clr;
      #1;
      chk("ready", {31'd0, ready}, {31'd0, exp_rdy});
      acc   = en && exp_rdy;
      inr   = int'(addr) < DEPTH;
      exp_v = acc && (rw == RW_READ) && inr;
      exp_e = acc && !inr;
      if (exp_v) sb_q.push_back(model[addr]);
      if (acc && (rw == RW_WRITE) && inr) model[addr] = din;
      @(posedge clk);
      #1;
      chk("valid", {31'd0, valid}, {31'd0, exp_v});
      chk("error", {31'd0, error}, {31'd0, exp_e});
      if (valid && sb_q.size() > 0) begin
         got = sb_q.pop_front();
         chk("rdata", {16'd0, D_Out}, {16'd0, got});
         chk("perr", {31'd0, perr}, {31'd0, perr_exp});
         last_dout = got;
      end else begin
         chk("dout_hold", {16'd0, D_Out}, {16'd0, last_dout});
         chk("perr_idle", {31'd0, perr}, 32'd0);
      end
      $display("txn en=%0b rw=%0b addr=%0d din=%h clr=%0b ready=%0b valid=%0b error=%0b perr=%0b dout=%h",
               en, rw, addr, din, clr, exp_rdy, valid, error, perr, D_Out);
   endtask

   task automatic zero_model();
      for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
   endtask

   task automatic check_reset_state();
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_dout",  {16'd0, D_Out}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_perr",  {31'd0, perr},  32'd0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      perr_exp  = 1'b0;
      last_dout = 16'h0000;
      reset     = 1'b1;
      enable    = 1'b0;
      R_W       = RW_READ;
      Address   = '0;
      D_In      = '0;
      clear     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      reset = 1'b0;

      // power-up sweep: ready low for DEPTH cycles, then every word reads 0
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, RW_READ, 3'd0, 16'h0, 1'b0, 1'b0);
      zero_model();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, RW_READ, 3'(i), 16'h0, 1'b0, 1'b1);

      // writes then back-to-back reads
      cycle(1'b1, RW_WRITE, 3'd0, 16'hAAAA, 1'b0, 1'b1);
      cycle(1'b1, RW_WRITE, 3'd2, 16'h00AA, 1'b0, 1'b1);
      cycle(1'b1, RW_WRITE, 3'd3, 16'h00BB, 1'b0, 1'b1);
      cycle(1'b1, RW_WRITE, 3'd5, 16'h00CC, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd0, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd2, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd3, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd5, 16'h0, 1'b0, 1'b1);

      // out-of-range accesses at and beyond DEPTH
      cycle(1'b1, RW_WRITE, 3'd7, 16'hFFFF, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd7, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, RW_WRITE, 3'd6, 16'hFFFF, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd6, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd0, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd5, 16'h0, 1'b0, 1'b1);

      // clear beats a same-cycle read; clear during the sweep is ignored
      cycle(1'b1, RW_WRITE, 3'd4, 16'h1234, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd4, 16'h0, 1'b1, 1'b0);
      zero_model();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, RW_READ, 3'd4, 16'h0, (i == 2), 1'b0);
      cycle(1'b1, RW_READ, 3'd4, 16'h0, 1'b0, 1'b1);

      // write then read the same address on consecutive cycles
      cycle(1'b1, RW_WRITE, 3'd1, 16'h5A5A, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd1, 16'h0, 1'b0, 1'b1);

      // reset three cycles into a sweep restarts it
      cycle(1'b0, RW_READ, 3'd0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, RW_READ, 3'd0, 16'h0, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      check_reset_state();
      last_dout = 16'h0000;
      #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, RW_READ, 3'd0, 16'h0, 1'b0, 1'b0);
      zero_model();
      cycle(1'b1, RW_WRITE, 3'd3, 16'hBEEF, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd3, 16'h0, 1'b0, 1'b1);

      // reset cancels an in-flight valid
      reset = 1'b1;
      #1;
      check_reset_state();
      last_dout = 16'h0000;
      #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, RW_READ, 3'd0, 16'h0, 1'b0, 1'b0);
      zero_model();

      // reset cancels an in-flight error
      cycle(1'b1, RW_READ, 3'd7, 16'h0, 1'b0, 1'b1);
      reset = 1'b1;
      #1;
      check_reset_state();
      #1;
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, RW_READ, 3'd0, 16'h0, 1'b0, 1'b0);
      cycle(1'b1, RW_READ, 3'd3, 16'h0, 1'b0, 1'b1);

`ifdef MEM_PARITY_EN
      // corrupt one stored data bit so the parity check trips
      cycle(1'b1, RW_WRITE, 3'd1, 16'h00FF, 1'b0, 1'b1);
      dut.u_array.Memory[1][0] = ~dut.u_array.Memory[1][0];
      model[1] = 16'h00FE;
      perr_exp = 1'b1;
      cycle(1'b1, RW_READ, 3'd1, 16'h0, 1'b0, 1'b1);
      perr_exp = 1'b0;
`else
      cycle(1'b1, RW_WRITE, 3'd1, 16'h00FF, 1'b0, 1'b1);
      cycle(1'b1, RW_READ,  3'd1, 16'h0, 1'b0, 1'b1);
`endif

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_bank.md
# memory_bank

Parametrised single-port synchronous data memory with a request/ready handshake, registered read data with a valid strobe, out-of-range detection and a hardware clear sequencer. It is the successor to the fixed 8×16 `memory` block. It sits between the processor's load/store unit and its data storage, and it is also the target of `$writememh` dumps in benches via the hierarchical array `Memory`.

## Interface
- `DATA_W`, 16: word width in bits.
- `ADDR_W`, 3: address width.
- `DEPTH`, 8: number of words; any value ≤ 2**ADDR_W, not necessarily a power of two.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: access request.
- `R_W` in 1: 0 = write, 1 = read.
- `Address` in ADDR_W: word address.
- `D_In` in DATA_W: write data.
- `clear` in 1: request a full zero-fill sweep.
- `ready` out 1: block can accept a request this cycle.
- `D_Out` out DATA_W: read data, registered.
- `valid` out 1: one-cycle strobe qualifying `D_Out`.
- `error` out 1: one-cycle strobe on an out-of-range access.
- `perr` out 1: one-cycle parity-error strobe accompanying `valid`.

## Operation
- FSM states: CLEAR, IDLE.
  - CLEAR: an internal counter `clr_addr` runs from 0 to DEPTH-1 and writes 0 to one word per cycle. After the write to DEPTH-1, go to IDLE. Sweep length is exactly DEPTH cycles.
  - IDLE: service requests. `clear`=1 sets `clr_addr`=0 and goes to CLEAR.
- `ready` = (state==IDLE) && !`clear`. This is combinational, so `clear` takes priority over a same-cycle request.
- A request is accepted when `enable` && `ready`.
- Write accepted with `Address` < DEPTH: `Memory[Address]` ← `D_In` at that edge.
- Read accepted with `Address` < DEPTH:
  - `D_Out` ← `Memory[Address]` at that edge.
  - `valid`=1 for the following cycle.
- Accepted request with `Address` ≥ DEPTH:
  - A write is dropped and memory is not modified.
  - A read leaves `D_Out` unchanged and does not assert `valid`.
  - `error`=1 for the following cycle.
- `enable` while not ready: ignored. No queuing and no error.
- `D_Out` holds its last read value until the next successful read. A clear sweep does not change it.
- Back-to-back write then read of the same address on consecutive cycles returns the new data.

## Timing
- Reset (asynchronous) puts the block in this state:
  - State = CLEAR and `clr_addr`=0.
  - `D_Out`=0, `valid`=0, `error`=0, `perr`=0.
  - `ready`=0.
- After reset deasserts, `ready` rises DEPTH cycles later.
- Reset asserted mid-sweep or mid-access restarts the sweep from 0. An in-flight `valid`/`error` is cancelled.
- Read latency: 1 cycle from the accepting edge to `valid`/`D_Out`.
- Write latency: 0; the data is visible to a read accepted at the next edge.
- Throughput: one request per cycle in IDLE.
- `clear` asserted during CLEAR: ignored; the sweep continues and is not restarted.

## Configuration
- `MEM_PARITY_EN` defined:
  - Each word stores one extra even-parity bit, written as ^`D_In`; the clear sweep stores 0.
  - On a read, parity is recomputed over the stored data. A mismatch drives `perr`=1 in the same cycle as `valid`.
- `MEM_PARITY_EN` undefined: no parity storage, and `perr` is tied to 0. The port list is identical in both builds.

## Structure
- Package `memory_pkg` holds:
  - The state enum `ST_CLEAR`, `ST_IDLE`.
  - The `R_W` encodings `RW_WRITE`=1'b0 and `RW_READ`=1'b1.
- Sub-module `memory_array`:
  - Pure storage with synchronous write and synchronous read.
  - Width is DATA_W, or DATA_W+1 with parity.
  - The array is named `Memory` so hierarchical dumps resolve as `ram.u_array.Memory`.
- The top level contains the FSM, clear counter, range check, parity logic and output registers.

## Test plan
- Reset with DEPTH=8 → `ready`=0 for 8 cycles, then 1. Dump shows all words 0000.
- Write AAAA to address 0, 00AA to 2, 00BB to 3, 00CC to 5, then read 0, 2, 3, 5 back to back → `valid` on 4 consecutive cycles with D_Out AAAA, 00AA, 00BB, 00CC.
- DEPTH=6, ADDR_W=3: write FFFF to address 7, then read address 7 → `error` pulses twice, no `valid`, and the dump is unchanged.
- Write 1234 to address 4, then assert `clear` together with `enable`+read of address 4:
  - No `valid`.
  - `ready` stays low for 6 cycles.
  - A read afterwards returns 0000.
- Assert `reset` at cycle 3 of a sweep → the sweep restarts. `ready` rises exactly DEPTH cycles after `reset` falls.
- With `MEM_PARITY_EN`: write 00FF to address 1, force one data bit of `Memory[1]` to flip, then read address 1 → `valid`=1 and `perr`=1 in the same cycle. Without the macro, `perr` stays 0.
